// File: rtl/rv_pkg.sv
// Shared RISC-E encodings and writeback-stage types.
package rv_pkg;

    // Major opcodes seen by the writeback stage
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    // Load funct3 encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    localparam int unsigned OPC_W = 7;
    localparam int unsigned F3_W  = 3;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

    // Normalised load kind after folding XLEN-dependent aliases
    typedef enum logic [2:0] {
        K_B, K_H, K_W, K_D, K_BU, K_HU, K_WU
    } ld_kind_e;

    // On a 32-bit core the 64-bit-only encodings degrade to LW; on 64-bit, 111 is LD
    function automatic ld_kind_e ld_kind(input logic [F3_W-1:0] f3, input logic is64);
        ld_kind_e k;
        case (f3)
            LB:      k = K_B;
            LH:      k = K_H;
            LW:      k = K_W;
            LBU:     k = K_BU;
            LHU:     k = K_HU;
            LD:      k = is64 ? K_D  : K_W;
            LWU:     k = is64 ? K_WU : K_W;
            default: k = is64 ? K_D  : K_W;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: shift by byte offset, extend, and flag misalignment.
module load_align
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]              raw_i,
    input  logic [$clog2(XLEN/8)-1:0]    offset_i,
    input  logic [F3_W-1:0]              funct3_i,
    output logic [XLEN-1:0]              ext_data_c_o,
    output logic                         misaligned_c_o
);

    localparam int unsigned OFF_W = $clog2(XLEN/8);
    localparam logic        IS64  = (XLEN == 64);

    logic [XLEN-1:0] shifted;
    ld_kind_e        kind;

    assign shifted = raw_i >> {offset_i, 3'b000};
    assign kind    = ld_kind(funct3_i, IS64);

    // Extend the shifted word and check natural alignment for the access size
    always_comb begin
        ext_data_c_o   = shifted;
        misaligned_c_o = 1'b0;
        case (kind)
            K_B:  ext_data_c_o = XLEN'($signed(shifted[7:0]));
            K_BU: ext_data_c_o = XLEN'(shifted[7:0]);
            K_H: begin
                ext_data_c_o   = XLEN'($signed(shifted[15:0]));
                misaligned_c_o = offset_i[0];
            end
            K_HU: begin
                ext_data_c_o   = XLEN'(shifted[15:0]);
                misaligned_c_o = offset_i[0];
            end
            K_W: begin
                ext_data_c_o   = XLEN'($signed(shifted[31:0]));
                misaligned_c_o = |offset_i[1:0];
            end
            K_WU: begin
                ext_data_c_o   = XLEN'(shifted[31:0]);
                misaligned_c_o = |offset_i[1:0];
            end
            K_D: begin
                ext_data_c_o   = shifted;
                misaligned_c_o = |offset_i[OFF_W-1:0];
            end
            default: begin
                ext_data_c_o   = shifted;
                misaligned_c_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/wb_stage_buffered.sv
// Registered writeback stage: one retire per cycle, loads parked until dmem responds.
module wb_stage_buffered
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [OPC_W-1:0]    in_opcode,
    input  logic [F3_W-1:0]     in_funct3,
    input  logic [RA_W-1:0]     in_rd,
    input  logic [XLEN-1:0]     in_alu_res,
    input  logic                dmem_rsp_valid,
    input  logic [XLEN-1:0]     dmem_rsp_data,
    output logic                rf_we,
    output logic [RA_W-1:0]     rf_waddr,
    output logic [XLEN-1:0]     rf_wdata,
    output logic                misalign_fault,
    output logic [XLEN-1:0]     fault_pc
);

    localparam int unsigned OFF_W = $clog2(XLEN/8);

    wb_state_e         state_q, state_d;
    logic [RA_W-1:0]   rd_q, rd_d;
    logic [F3_W-1:0]   funct3_q, funct3_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              rf_we_q, rf_we_d;
    logic [RA_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic              fault_q, fault_d;
    logic [XLEN-1:0]   fault_pc_q, fault_pc_d;

    logic [OFF_W-1:0]  align_off;
    logic [F3_W-1:0]   align_f3;
    logic [XLEN-1:0]   load_data;
    logic              load_misaligned;
    logic              writes_rd;
    logic              is_link;

    // Aligner sees the incoming instruction in IDLE (fault check) and the parked load otherwise
    assign align_off = (state_q == IDLE) ? in_alu_res[OFF_W-1:0] : off_q;
    assign align_f3  = (state_q == IDLE) ? in_funct3 : funct3_q;

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .raw_i          (dmem_rsp_data),
        .offset_i       (align_off),
        .funct3_i       (align_f3),
        .ext_data_c_o   (load_data),
        .misaligned_c_o (load_misaligned)
    );

    assign in_ready  = (state_q == IDLE);
    assign writes_rd = (in_opcode != STORE) && (in_opcode != BRANCH) && (in_rd != '0);
    assign is_link   = (in_opcode == JAL) || (in_opcode == JALR);

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        fault_d    = 1'b0;
        fault_pc_d = fault_pc_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_opcode == LOAD) begin
                        if (load_misaligned) begin
                            fault_d    = 1'b1;
                            fault_pc_d = in_pc;
                        end else begin
                            rd_d     = in_rd;
                            funct3_d = in_funct3;
                            off_d    = in_alu_res[OFF_W-1:0];
                            state_d  = WAIT_MEM;
                        end
                    end else if (writes_rd) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = in_rd;
                        rf_wdata_d = is_link ? (in_pc + XLEN'(4)) : in_alu_res;
                    end
                end
            end
            WAIT_MEM: begin
                if (dmem_rsp_valid) begin
                    state_d = IDLE;
                    if (rd_q != '0) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = rd_q;
                        rf_wdata_d = load_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            funct3_q   <= '0;
            off_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    assign rf_we          = rf_we_q;
    assign rf_waddr       = rf_waddr_q;
    assign rf_wdata       = rf_wdata_q;
    assign misalign_fault = fault_q;
    assign fault_pc       = fault_pc_q;

endmodule

// File: tb/tb_wb_stage_buffered.sv
// Directed bench for wb_stage_buffered at XLEN=32 and XLEN=64.
module tb_wb_stage_buffered;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // XLEN=32 instance signals
    logic        a_valid, a_ready, a_rsp_v, a_we, a_fault;
    logic [31:0] a_pc, a_alu, a_rsp_d, a_wdata, a_fpc;
    logic [6:0]  a_opc;
    logic [2:0]  a_f3;
    logic [4:0]  a_rd, a_waddr;

    // XLEN=64 instance signals
    logic        b_valid, b_ready, b_rsp_v, b_we, b_fault;
    logic [63:0] b_pc, b_alu, b_rsp_d, b_wdata, b_fpc;
    logic [6:0]  b_opc;
    logic [2:0]  b_f3;
    logic [4:0]  b_rd, b_waddr;

    wb_stage_buffered #(.XLEN(32), .RA_W(5)) u32 (
        .clk(clk), .rst(rst),
        .in_valid(a_valid), .in_ready(a_ready), .in_pc(a_pc), .in_opcode(a_opc),
        .in_funct3(a_f3), .in_rd(a_rd), .in_alu_res(a_alu),
        .dmem_rsp_valid(a_rsp_v), .dmem_rsp_data(a_rsp_d),
        .rf_we(a_we), .rf_waddr(a_waddr), .rf_wdata(a_wdata),
        .misalign_fault(a_fault), .fault_pc(a_fpc)
    );

    wb_stage_buffered #(.XLEN(64), .RA_W(5)) u64 (
        .clk(clk), .rst(rst),
        .in_valid(b_valid), .in_ready(b_ready), .in_pc(b_pc), .in_opcode(b_opc),
        .in_funct3(b_f3), .in_rd(b_rd), .in_alu_res(b_alu),
        .dmem_rsp_valid(b_rsp_v), .dmem_rsp_data(b_rsp_d),
        .rf_we(b_we), .rf_waddr(b_waddr), .rf_wdata(b_wdata),
        .misalign_fault(b_fault), .fault_pc(b_fpc)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] alu;
        logic        we;
        logic [31:0] wdata;
        logic        fault;
    } vec_t;

    vec_t tv[10];

    // Expected held values for the 32-bit instance
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [31:0] e_fpc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 32-bit aligned load, response arrives on the third cycle after accept
    task automatic load32(input logic [2:0] f3, input logic [31:0] alu, input logic [4:0] rd,
                          input logic [31:0] rsp, input logic [31:0] exp);
        a_opc = 7'b0000011; a_f3 = f3; a_alu = alu; a_rd = rd; a_pc = 32'h400;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        chk("ld32_we_after_accept", 64'(a_we), 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("ld32_ready_low", 64'(a_ready), 64'd0);
            if (i == 2) begin
                a_rsp_v = 1'b1;
                a_rsp_d = rsp;
            end
            tick();
        end
        a_rsp_v = 1'b0;
        chk("ld32_we", 64'(a_we), 64'd1);
        chk("ld32_waddr", 64'(a_waddr), 64'(rd));
        chk("ld32_wdata", 64'(a_wdata), 64'(exp));
        chk("ld32_ready_back", 64'(a_ready), 64'd1);
        tick();
        chk("ld32_we_pulse", 64'(a_we), 64'd0);
        chk("ld32_wdata_hold", 64'(a_wdata), 64'(exp));
        e_waddr = rd;
        e_wdata = exp;
    endtask

    // 64-bit aligned load, response on the cycle after accept
    task automatic load64(input logic [2:0] f3, input logic [63:0] alu, input logic [4:0] rd,
                          input logic [63:0] rsp, input logic [63:0] exp);
        b_opc = 7'b0000011; b_f3 = f3; b_alu = alu; b_rd = rd; b_pc = 64'h800;
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        chk("ld64_ready_low", 64'(b_ready), 64'd0);
        b_rsp_v = 1'b1;
        b_rsp_d = rsp;
        tick();
        b_rsp_v = 1'b0;
        chk("ld64_we", 64'(b_we), 64'd1);
        chk("ld64_waddr", 64'(b_waddr), 64'(rd));
        chk("ld64_wdata", b_wdata, exp);
        chk("ld64_ready_back", 64'(b_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{7'b0010011, 3'b000, 5'd5,  32'h0,   32'h1234,     1'b1, 32'h00001234, 1'b0};
        tv[1] = '{7'b1101111, 3'b000, 5'd1,  32'h100, 32'hDEAD,     1'b1, 32'h00000104, 1'b0};
        tv[2] = '{7'b1100111, 3'b000, 5'd31, 32'h200, 32'h5,        1'b1, 32'h00000204, 1'b0};
        tv[3] = '{7'b0100011, 3'b010, 5'd7,  32'h204, 32'h99,       1'b0, 32'h0,        1'b0};
        tv[4] = '{7'b1100011, 3'b000, 5'd3,  32'h208, 32'h1,        1'b0, 32'h0,        1'b0};
        tv[5] = '{7'b0010011, 3'b000, 5'd0,  32'h20C, 32'h77,       1'b0, 32'h0,        1'b0};
        tv[6] = '{7'b0110111, 3'b000, 5'd10, 32'h210, 32'hABCD0000, 1'b1, 32'hABCD0000, 1'b0};
        tv[7] = '{7'b0000011, 3'b001, 5'd4,  32'h300, 32'h1001,     1'b0, 32'h0,        1'b1};
        tv[8] = '{7'b0000011, 3'b010, 5'd4,  32'h304, 32'h2002,     1'b0, 32'h0,        1'b1};
        tv[9] = '{7'b0110011, 3'b000, 5'd2,  32'h308, 32'h55,       1'b1, 32'h00000055, 1'b0};

        rst = 1'b1;
        a_valid = 0; a_pc = 0; a_opc = 0; a_f3 = 0; a_rd = 0; a_alu = 0; a_rsp_v = 0; a_rsp_d = 0;
        b_valid = 0; b_pc = 0; b_opc = 0; b_f3 = 0; b_rd = 0; b_alu = 0; b_rsp_v = 0; b_rsp_d = 0;
        e_waddr = 0; e_wdata = 0; e_fpc = 0;
        tick();
        tick();
        chk("rst_ready32", 64'(a_ready), 64'd1);
        chk("rst_we32", 64'(a_we), 64'd0);
        chk("rst_waddr32", 64'(a_waddr), 64'd0);
        chk("rst_wdata32", 64'(a_wdata), 64'd0);
        chk("rst_fault32", 64'(a_fault), 64'd0);
        chk("rst_fpc32", 64'(a_fpc), 64'd0);
        chk("rst_ready64", 64'(b_ready), 64'd1);
        chk("rst_wdata64", b_wdata, 64'd0);
        rst = 1'b0;

        // Back-to-back single-cycle vectors, one accept per clock
        for (int i = 0; i < 10; i++) begin
            a_opc = tv[i].opc; a_f3 = tv[i].f3; a_rd = tv[i].rd;
            a_pc = tv[i].pc; a_alu = tv[i].alu; a_valid = 1'b1;
            tick();
            if (tv[i].we) begin
                e_waddr = tv[i].rd;
                e_wdata = tv[i].wdata;
            end
            if (tv[i].fault) e_fpc = tv[i].pc;
            chk($sformatf("v%0d_we", i), 64'(a_we), 64'(tv[i].we));
            chk($sformatf("v%0d_waddr", i), 64'(a_waddr), 64'(e_waddr));
            chk($sformatf("v%0d_wdata", i), 64'(a_wdata), 64'(e_wdata));
            chk($sformatf("v%0d_fault", i), 64'(a_fault), 64'(tv[i].fault));
            chk($sformatf("v%0d_fpc", i), 64'(a_fpc), 64'(e_fpc));
            chk($sformatf("v%0d_ready", i), 64'(a_ready), 64'd1);
        end
        a_valid = 1'b0;

        // Byte loads at offset 3 with sign and zero extension
        load32(3'b000, 32'h1003, 5'd6, 32'h80FFFFFF, 32'hFFFFFF80);
        load32(3'b100, 32'h1003, 5'd7, 32'h80FFFFFF, 32'h00000080);
        // Funct3 011 on a 32-bit core behaves as LW
        load32(3'b011, 32'h2000, 5'd8, 32'h8000_0001, 32'h8000_0001);

        // Response strobe while idle must not write
        a_rsp_v = 1'b1; a_rsp_d = 32'hCAFEBABE;
        tick();
        a_rsp_v = 1'b0;
        chk("idle_rsp_we", 64'(a_we), 64'd0);
        chk("idle_rsp_wdata", 64'(a_wdata), 64'(e_wdata));
        chk("idle_rsp_ready", 64'(a_ready), 64'd1);

        // 64-bit word/doubleword loads
        load64(3'b110, 64'h1004, 5'd9,  64'h89ABCDEF_00000000, 64'h00000000_89ABCDEF);
        load64(3'b010, 64'h1004, 5'd10, 64'h89ABCDEF_00000000, 64'hFFFFFFFF_89ABCDEF);
        load64(3'b011, 64'h1000, 5'd11, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF);
        load64(3'b101, 64'h1006, 5'd12, 64'hF00D_0000_0000_0000, 64'h0000_0000_0000_F00D);

        // Misaligned LD on the 64-bit core
        b_opc = 7'b0000011; b_f3 = 3'b011; b_alu = 64'h1004; b_rd = 5'd13;
        b_pc = 64'h1_0000_0040; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        chk("ld64_mis_fault", 64'(b_fault), 64'd1);
        chk("ld64_mis_fpc", b_fpc, 64'h1_0000_0040);
        chk("ld64_mis_we", 64'(b_we), 64'd0);
        chk("ld64_mis_ready", 64'(b_ready), 64'd1);
        tick();
        chk("ld64_mis_pulse", 64'(b_fault), 64'd0);
        chk("ld64_mis_fpc_hold", b_fpc, 64'h1_0000_0040);

        // Reset while waiting on memory abandons the load
        a_opc = 7'b0000011; a_f3 = 3'b010; a_alu = 32'h3000; a_rd = 5'd9; a_pc = 32'h500;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        chk("rstw_ready_low", 64'(a_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_ready", 64'(a_ready), 64'd1);
        chk("rstw_waddr", 64'(a_waddr), 64'd0);
        chk("rstw_wdata", 64'(a_wdata), 64'd0);
        chk("rstw_fpc", 64'(a_fpc), 64'd0);
        a_rsp_v = 1'b1; a_rsp_d = 32'h12345678;
        tick();
        a_rsp_v = 1'b0;
        chk("rstw_late_we", 64'(a_we), 64'd0);
        chk("rstw_late_wdata", 64'(a_wdata), 64'd0);
        chk("rstw_late_ready", 64'(a_ready), 64'd1);
        chk("rstw_fault", 64'(a_fault), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_stage_buffered.md
# wb_stage_buffered

Registered, parametrised writeback stage for the RISC-E pipeline. It accepts one retiring instruction per cycle over a valid/ready handshake and holds loads until the data-memory response arrives. It aligns and sign/zero-extends load data using the effective-address byte offset, and drives the register-file write port from a register. It supports XLEN=32 and XLEN=64, where 64 adds LWU/LD, and flags misaligned loads instead of writing them back.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- RA_W, 5, register address width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  retiring instruction present
- in_ready  out  1  stage can accept; equals (state == IDLE)
- in_pc  in  XLEN  instruction PC
- in_opcode  in  7  instruction opcode
- in_funct3  in  3  instruction funct3
- in_rd  in  RA_W  destination register
- in_alu_res  in  XLEN  ALU result; the effective address for loads
- dmem_rsp_valid  in  1  data-memory response strobe
- dmem_rsp_data  in  XLEN  raw naturally-aligned memory word
- rf_we  out  1  register-file write enable, one-cycle pulse
- rf_waddr  out  RA_W  write address
- rf_wdata  out  XLEN  write data
- misalign_fault  out  1  one-cycle pulse on misaligned load
- fault_pc  out  XLEN  PC of the faulting load; held until the next fault

## Operation
- Opcodes:
  - LOAD 0000011
  - STORE 0100011
  - BRANCH 1100011
  - JAL 1101111
  - JALR 1100111
- States: IDLE, WAIT_MEM.
- IDLE, accept (in_valid && in_ready):
  - Non-load: compute the result and register it. rf_wdata = in_pc+4 for JAL/JALR, otherwise in_alu_res. rf_we = 1 unless the opcode is STORE/BRANCH or in_rd == 0. Stay in IDLE.
  - Load, aligned: latch rd, funct3 and offset (in_alu_res[log2(XLEN/8)-1:0]), then go to WAIT_MEM.
  - Load, misaligned: pulse misalign_fault, load fault_pc, keep rf_we = 0 and stay in IDLE. Misaligned means LH/LHU with offset[0]; LW/LWU with offset[1:0] != 0; LD with offset[2:0] != 0. Upstream does not issue misaligned loads to memory.
- WAIT_MEM: in_ready = 0. On dmem_rsp_valid, register the load result, pulse rf_we (if rd != 0) and return to IDLE.
- Load extraction:
  - Shift dmem_rsp_data right by 8*offset.
  - LB/LH/LW sign-extend from bit 7/15/31.
  - LBU/LHU/LWU zero-extend.
  - LD passes all 64 bits.
  - For XLEN=32, funct3 011, 110 and 111 behave as LW. For XLEN=64, 111 behaves as LD.
- dmem_rsp_valid in IDLE is ignored.
- rf_waddr/rf_wdata update only when rf_we is set and hold their value otherwise.

## Timing
- Non-load accepted at cycle N: rf_we high at N+1. Sustained throughput is one instruction per cycle.
- Load accepted at N, response at M (M ≥ N+1): rf_we at M+1. A new instruction can be accepted no earlier than M+1.
- Misaligned load accepted at N: misalign_fault high at N+1 only. in_ready never deasserts.
- Reset values:
  - state IDLE
  - in_ready 1 (combinational from state)
  - rf_we 0, rf_waddr 0, rf_wdata 0
  - misalign_fault 0, fault_pc 0
- Reset during WAIT_MEM abandons the load: no write occurs, and a late response is dropped in IDLE.
- in_ready depends only on state; there is no combinational path from in_valid.

## Structure
- Shared package rv_pkg: opcode localparams (LOAD, STORE, BRANCH, JAL, JALR) and funct3 load encodings (LB, LH, LW, LD, LBU, LHU, LWU).
- Sub-module load_align (combinational), parametrised by XLEN. Inputs: raw data, offset, funct3. Outputs: extended data and misaligned flag. The misaligned flag is evaluated at accept time on in_alu_res; the data path is used in WAIT_MEM.

## Test plan
- XLEN=32, ADDI-style opcode 0010011, rd=5, alu_res=0x1234 → next cycle rf_we=1, waddr=5, wdata=0x00001234.
- JAL, pc=0x100, rd=1 → wdata=0x104. STORE and rd=0 cases → rf_we stays 0.
- LB, addr offset 3, response 0x80FFFFFF after 3 cycles → in_ready low for 3 cycles, then wdata=0xFFFFFF80. LBU with the same stimulus → 0x00000080.
- LH at offset 1 → misalign_fault pulse, fault_pc=in_pc, no rf_we, in_ready stays 1.
- XLEN=64: LWU offset 4, response 0x89ABCDEF_00000000 → 0x00000000_89ABCDEF. LW with the same stimulus → 0xFFFFFFFF_89ABCDEF.
- rst asserted while in WAIT_MEM, response the following cycle → no rf_we, state IDLE, all outputs at reset values.
